// File: rtl/cache_arb_pkg.sv
// Shared types and default widths for the I/D cache-to-L2 arbiter.
package cache_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

endpackage

// File: rtl/cache_arbiter_if.sv
// I-side, D-side and downstream memory buses of the cache arbiter.
interface cache_arbiter_if
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
);

  logic              i_mem_read;
  logic [ADDR_W-1:0] i_mem_address;
  logic [LINE_W-1:0] i_mem_rdata;
  logic              i_mem_resp;

  logic              d_mem_read;
  logic              d_mem_write;
  logic [ADDR_W-1:0] d_mem_address;
  logic [LINE_W-1:0] d_mem_wdata;
  logic [LINE_W-1:0] d_mem_rdata;
  logic              d_mem_resp;

  logic              l2_mem_read;
  logic              l2_mem_write;
  logic [ADDR_W-1:0] l2_mem_address;
  logic [LINE_W-1:0] l2_mem_wdata;
  logic [LINE_W-1:0] l2_mem_rdata;
  logic              l2_mem_resp;

  // The arbiter is the slave of both caches and the master of L2.
  modport slave (
    input  i_mem_read, i_mem_address, d_mem_read, d_mem_write,
    input  d_mem_address, d_mem_wdata, l2_mem_rdata, l2_mem_resp,
    output i_mem_rdata, i_mem_resp, d_mem_rdata, d_mem_resp,
    output l2_mem_read, l2_mem_write, l2_mem_address, l2_mem_wdata
  );

  modport master (
    output i_mem_read, i_mem_address, d_mem_read, d_mem_write,
    output d_mem_address, d_mem_wdata, l2_mem_rdata, l2_mem_resp,
    input  i_mem_rdata, i_mem_resp, d_mem_rdata, d_mem_resp,
    input  l2_mem_read, l2_mem_write, l2_mem_address, l2_mem_wdata
  );

endinterface

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto one downstream port.
// Define CACHE_ARB_ROUND_ROBIN_EN for round-robin; default is fixed D priority.
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input logic             clk,
  input logic             rst,
  cache_arbiter_if.slave  bus
);

  arb_state_e        state_q, state_d;
  logic              i_req, d_req, d_wins;
  logic              l2_read, l2_write, i_resp, d_resp;
  logic [ADDR_W-1:0] l2_addr;
  logic [LINE_W-1:0] line_rdata;

  assign i_req = bus.i_mem_read;
  assign d_req = bus.d_mem_read | bus.d_mem_write;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  grant_e last_grant_q, last_grant_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_grant_q <= GRANT_I;
    else      last_grant_q <= last_grant_d;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == IDLE && state_d == SERVE_D) last_grant_d = GRANT_D;
    else if (state_q == IDLE && state_d == SERVE_I) last_grant_d = GRANT_I;
  end

  assign d_wins = (last_grant_q == GRANT_I);
`else
  assign d_wins = 1'b1;
`endif

  // NOTE: every combinational output is defaulted first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    l2_read  = 1'b0;
    l2_write = 1'b0;
    l2_addr  = bus.i_mem_address;
    i_resp   = 1'b0;
    d_resp   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_req && d_req) state_d = d_wins ? SERVE_D : SERVE_I;
        else if (d_req)     state_d = SERVE_D;
        else if (i_req)     state_d = SERVE_I;
      end
      SERVE_I: begin
        l2_read = 1'b1;
        i_resp  = bus.l2_mem_resp;
        if (bus.l2_mem_resp) state_d = IDLE;
      end
      SERVE_D: begin
        // A simultaneous read and write-back resolves to the write.
        l2_write = bus.d_mem_write;
        l2_read  = bus.d_mem_read & ~bus.d_mem_write;
        l2_addr  = bus.d_mem_address;
        d_resp   = bus.l2_mem_resp;
        if (bus.l2_mem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign line_rdata         = bus.l2_mem_rdata;
  assign bus.i_mem_rdata    = line_rdata;
  assign bus.d_mem_rdata    = line_rdata;
  assign bus.i_mem_resp     = i_resp;
  assign bus.d_mem_resp     = d_resp;
  assign bus.l2_mem_read    = l2_read;
  assign bus.l2_mem_write   = l2_write;
  assign bus.l2_mem_address = l2_addr;
  assign bus.l2_mem_wdata   = bus.d_mem_wdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter (both arbitration builds).
module tb_cache_arbiter;
  import cache_arb_pkg::*;

  localparam logic [31:0]  I_ADDR  = 32'h0000_1000;
  localparam logic [31:0]  D_ADDR  = 32'h0000_2040;
  localparam logic [31:0]  CI_ADDR = 32'h0000_4000;
  localparam logic [31:0]  CD_ADDR = 32'h0000_3000;
  localparam logic [255:0] DATA_A  = {8{32'hAAAA_AAAA}};
  localparam logic [255:0] DATA_5  = {8{32'h5555_5555}};

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  cache_arbiter_if #(.ADDR_W(32), .LINE_W(256)) bus ();

  cache_arbiter #(.ADDR_W(32), .LINE_W(256)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.i_mem_read    = 1'b0;
    bus.i_mem_address = '0;
    bus.d_mem_read    = 1'b0;
    bus.d_mem_write   = 1'b0;
    bus.d_mem_address = '0;
    bus.d_mem_wdata   = '0;
    bus.l2_mem_rdata  = '0;
    bus.l2_mem_resp   = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    bus.d_mem_read    = 1'b1;
    bus.d_mem_address = D_ADDR;
    tick();
    #1;
    checks++;
    if (bus.l2_mem_read !== 1'b1) begin
      failures++; $display("FAIL rst_pre_serve_d: l2_mem_read got %b expected 1", bus.l2_mem_read);
    end
    bus.l2_mem_resp = 1'b1;
    #1 rst = 1'b0;
    #1;
    checks++;
    if (bus.l2_mem_read !== 1'b0 || bus.l2_mem_write !== 1'b0) begin
      failures++; $display("FAIL rst_async_strobes: rd/wr got %b%b expected 00", bus.l2_mem_read, bus.l2_mem_write);
    end
    checks++;
    if (bus.d_mem_resp !== 1'b0 || bus.i_mem_resp !== 1'b0) begin
      failures++; $display("FAIL rst_abandon_resp: d/i resp got %b%b expected 00", bus.d_mem_resp, bus.i_mem_resp);
    end
    tick();
    bus.d_mem_read = 1'b0;
    tick();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      #1;
      checks++;
      if (bus.l2_mem_read !== 1'b0 || bus.d_mem_resp !== 1'b0 || bus.i_mem_resp !== 1'b0) begin
        failures++;
        $display("FAIL rst_idle_ignore_resp[%0d]: rd/dresp/iresp got %b%b%b expected 000",
                 c, bus.l2_mem_read, bus.d_mem_resp, bus.i_mem_resp);
      end
    end
    clear_inputs();
  endtask

  task automatic test_i_read();
    tick();
    bus.i_mem_read    = 1'b1;
    bus.i_mem_address = I_ADDR;
    #1;
    checks++;
    if (bus.l2_mem_read !== 1'b0) begin
      failures++; $display("FAIL i_read_latency: l2_mem_read at N got %b expected 0", bus.l2_mem_read);
    end
    tick();
    #1;
    checks++;
    if (bus.l2_mem_read !== 1'b1 || bus.l2_mem_write !== 1'b0 || bus.l2_mem_address !== I_ADDR) begin
      failures++;
      $display("FAIL i_read_strobe: rd/wr/addr got %b/%b/%h expected 1/0/%h",
               bus.l2_mem_read, bus.l2_mem_write, bus.l2_mem_address, I_ADDR);
    end
    repeat (2) tick();
    #1;
    checks++;
    if (bus.l2_mem_read !== 1'b1 || bus.i_mem_resp !== 1'b0) begin
      failures++; $display("FAIL i_read_hold: rd/resp at N+3 got %b%b expected 10", bus.l2_mem_read, bus.i_mem_resp);
    end
    tick();
    bus.l2_mem_resp  = 1'b1;
    bus.l2_mem_rdata = DATA_A;
    #1;
    checks++;
    if (bus.i_mem_resp !== 1'b1 || bus.i_mem_rdata !== DATA_A) begin
      failures++; $display("FAIL i_read_resp: resp/data got %b/%h expected 1/%h", bus.i_mem_resp, bus.i_mem_rdata, DATA_A);
    end
    checks++;
    if (bus.d_mem_resp !== 1'b0) begin
      failures++; $display("FAIL i_read_no_d_resp: d_mem_resp got %b expected 0", bus.d_mem_resp);
    end
    bus.i_mem_read = 1'b0;
    tick();
    #1;
    checks++;
    if (bus.l2_mem_read !== 1'b0 || bus.i_mem_resp !== 1'b0) begin
      failures++; $display("FAIL i_read_idle: rd/resp at N+5 got %b%b expected 00", bus.l2_mem_read, bus.i_mem_resp);
    end
    clear_inputs();
  endtask

  task automatic test_d_write();
    tick();
    bus.d_mem_write   = 1'b1;
    bus.d_mem_address = D_ADDR;
    bus.d_mem_wdata   = DATA_5;
    tick();
    #1;
    checks++;
    if (bus.l2_mem_write !== 1'b1 || bus.l2_mem_read !== 1'b0 ||
        bus.l2_mem_address !== D_ADDR || bus.l2_mem_wdata !== DATA_5) begin
      failures++;
      $display("FAIL d_write_strobe: wr/rd/addr got %b/%b/%h expected 1/0/%h", bus.l2_mem_write,
               bus.l2_mem_read, bus.l2_mem_address, D_ADDR);
    end
    tick();
    bus.l2_mem_resp = 1'b1;
    #1;
    checks++;
    if (bus.d_mem_resp !== 1'b1 || bus.i_mem_resp !== 1'b0) begin
      failures++; $display("FAIL d_write_resp: d/i resp got %b%b expected 10", bus.d_mem_resp, bus.i_mem_resp);
    end
    bus.d_mem_write = 1'b0;
    tick();
    #1;
    checks++;
    if (bus.d_mem_resp !== 1'b0 || bus.l2_mem_write !== 1'b0) begin
      failures++; $display("FAIL d_write_single_pulse: resp/wr got %b%b expected 00", bus.d_mem_resp, bus.l2_mem_write);
    end
    bus.l2_mem_resp = 1'b0;
    // Read and write-back together: the write must win.
    bus.d_mem_read  = 1'b1;
    bus.d_mem_write = 1'b1;
    tick();
    #1;
    checks++;
    if (bus.l2_mem_write !== 1'b1 || bus.l2_mem_read !== 1'b0) begin
      failures++; $display("FAIL d_rw_write_wins: wr/rd got %b%b expected 10", bus.l2_mem_write, bus.l2_mem_read);
    end
    bus.l2_mem_resp = 1'b1;
    tick();
    bus.d_mem_read  = 1'b0;
    bus.d_mem_write = 1'b0;
    bus.l2_mem_resp = 1'b0;
    clear_inputs();
  endtask

  task automatic test_contention();
    logic        exp_d;
    logic [31:0] exp_addr;
    do_reset();
    bus.i_mem_read    = 1'b1;
    bus.i_mem_address = CI_ADDR;
    bus.d_mem_read    = 1'b1;
    bus.d_mem_address = CD_ADDR;
    for (int t = 0; t < 4; t++) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      exp_d = (t % 2 == 0);
`else
      exp_d = (t < 3);
      if (t == 3) bus.d_mem_read = 1'b0;
`endif
      exp_addr = exp_d ? CD_ADDR : CI_ADDR;
      tick();
      #1;
      checks++;
      if (bus.l2_mem_read !== 1'b1 || bus.l2_mem_address !== exp_addr) begin
        failures++;
        $display("FAIL contention_grant[%0d]: rd/addr got %b/%h expected 1/%h", t, bus.l2_mem_read,
                 bus.l2_mem_address, exp_addr);
      end
      bus.l2_mem_resp = 1'b1;
      #1;
      checks++;
      if (bus.d_mem_resp !== exp_d || bus.i_mem_resp !== !exp_d) begin
        failures++;
        $display("FAIL contention_resp[%0d]: d/i resp got %b%b expected %b%b", t, bus.d_mem_resp,
                 bus.i_mem_resp, exp_d, !exp_d);
      end
      tick();
      bus.l2_mem_resp = 1'b0;
      #1;
      checks++;
      if (bus.l2_mem_read !== 1'b0 || bus.l2_mem_write !== 1'b0) begin
        failures++; $display("FAIL contention_bubble[%0d]: rd/wr got %b%b expected 00", t, bus.l2_mem_read, bus.l2_mem_write);
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_abandon();
    tick();
    bus.i_mem_read    = 1'b1;
    bus.i_mem_address = I_ADDR;
    tick();
    #1;
    checks++;
    if (bus.l2_mem_read !== 1'b1) begin
      failures++; $display("FAIL abandon_grant: l2_mem_read got %b expected 1", bus.l2_mem_read);
    end
    tick();
    bus.i_mem_read = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      #1;
      checks++;
      if (bus.l2_mem_read !== 1'b1) begin
        failures++; $display("FAIL abandon_hold[%0d]: l2_mem_read got %b expected 1", c, bus.l2_mem_read);
      end
    end
    tick();
    bus.l2_mem_resp = 1'b1;
    #1;
    checks++;
    if (bus.d_mem_resp !== 1'b0 || bus.i_mem_resp !== 1'b1) begin
      failures++; $display("FAIL abandon_resp: d/i resp got %b%b expected 01", bus.d_mem_resp, bus.i_mem_resp);
    end
    tick();
    bus.l2_mem_resp = 1'b0;
    #1;
    checks++;
    if (bus.l2_mem_read !== 1'b0 || bus.d_mem_resp !== 1'b0) begin
      failures++; $display("FAIL abandon_idle: rd/dresp got %b%b expected 00", bus.l2_mem_read, bus.d_mem_resp);
    end
    clear_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    clear_inputs();
    bus.d_mem_read  = 1'b1;
    bus.l2_mem_resp = 1'b1;
    #12;
    checks++;
    if (bus.l2_mem_read !== 1'b0 || bus.d_mem_resp !== 1'b0 || bus.i_mem_resp !== 1'b0) begin
      failures++; $display("FAIL reset_state: rd/dresp/iresp got %b%b%b expected 000", bus.l2_mem_read,
                           bus.d_mem_resp, bus.i_mem_resp);
    end
    clear_inputs();
    test_reset();
    test_i_read();
    test_d_write();
    test_contention();
    test_abandon();
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
